// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and the flag bundle.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_INC  = 4'd2,
    OP_DEC  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_SHL  = 4'd7,
    OP_SHR  = 4'd8,
    OP_MUL  = 4'd9,
    OP_PASS = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic neg;
    logic ovf;
  } alu_flags_t;

  localparam logic [3:0] OP_LAST_LEGAL = 4'd10;

endpackage

// File: rtl/alu_seq_if.sv
// Valid/ready operand and result bus of alu_seq; master is producer+consumer, slave is the ALU.
interface alu_seq_if #(parameter int WIDTH = 8) ();
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  alu_op_e          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_zero;
  logic             flag_carry;
  logic             flag_neg;
  logic             flag_ovf;
  logic             err_illegal;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flag_zero, flag_carry, flag_neg, flag_ovf, err_illegal
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flag_zero, flag_carry, flag_neg, flag_ovf, err_illegal
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier, one bit of b per cycle for WIDTH cycles.
// done and product are combinational during the final iteration so the caller can register them on that edge.
module alu_mul_seq #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done
);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] addend;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               busy;

  assign addend  = mplier[0] ? mcand : '0;
  assign product = acc + addend;
  assign done    = busy && (cnt == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= CNT_W'(WIDTH);
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flags held until accepted.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier (op 9); otherwise op 9 is illegal.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);

  localparam int MSB = WIDTH - 1;

  alu_state_e       state, state_next;
  logic [WIDTH-1:0] result_q, alu_res, mul_res;
  alu_flags_t       flags_q, alu_flags, mul_flags;
  logic             err_q, alu_err;
  logic [WIDTH:0]   wide;
  logic             in_ready, accept, is_mul, load_alu, load_mul, mul_done;

  assign in_ready = !rst && ((state == ST_IDLE) || (state == ST_DONE && bus.out_ready));
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    wide      = '0;
    alu_res   = '0;
    alu_flags = '0;
    alu_err   = 1'b0;
    is_mul    = 1'b0;
    case (bus.op)
      OP_ADD: begin
        wide            = {1'b0, bus.a} + {1'b0, bus.b};
        alu_res         = wide[MSB:0];
        alu_flags.carry = wide[WIDTH];
        alu_flags.ovf   = (bus.a[MSB] == bus.b[MSB]) && (alu_res[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        wide            = {1'b0, bus.a} - {1'b0, bus.b};
        alu_res         = wide[MSB:0];
        alu_flags.carry = wide[WIDTH];
        alu_flags.ovf   = (bus.a[MSB] != bus.b[MSB]) && (alu_res[MSB] != bus.a[MSB]);
      end
      OP_INC: begin
        wide            = {1'b0, bus.b} + (WIDTH+1)'(1);
        alu_res         = wide[MSB:0];
        alu_flags.carry = wide[WIDTH];
        alu_flags.ovf   = !bus.b[MSB] && alu_res[MSB];
      end
      OP_DEC: begin
        wide            = {1'b0, bus.b} - (WIDTH+1)'(1);
        alu_res         = wide[MSB:0];
        alu_flags.carry = wide[WIDTH];
        alu_flags.ovf   = bus.b[MSB] && !alu_res[MSB];
      end
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_SHL: begin
        alu_res         = bus.a << 1;
        alu_flags.carry = bus.a[MSB];
      end
      OP_SHR: begin
        alu_res         = bus.a >> 1;
        alu_flags.carry = bus.a[0];
      end
      OP_PASS: alu_res = bus.b;
`ifdef ALU_SEQ_MUL_EN
      OP_MUL:  is_mul = 1'b1;
`endif
      default: alu_err = 1'b1;
    endcase
    alu_flags.zero = (alu_res == '0);
    alu_flags.neg  = alu_res[MSB];
  end

`ifdef ALU_SEQ_MUL_EN
  logic                 mul_start;
  logic [2*WIDTH-1:0]   product;

  assign mul_start = accept && is_mul;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .product (product),
    .done    (mul_done)
  );

  // Multiply overflow is reported whenever the discarded high half is non-zero.
  always_comb begin
    mul_res         = product[MSB:0];
    mul_flags.zero  = (mul_res == '0);
    mul_flags.carry = |product[2*WIDTH-1:WIDTH];
    mul_flags.neg   = mul_res[MSB];
    mul_flags.ovf   = |product[2*WIDTH-1:WIDTH];
  end
`else
  assign mul_done  = 1'b0;
  assign mul_res   = '0;
  assign mul_flags = '0;
`endif

  always_comb begin
    state_next = state;
    load_alu   = 1'b0;
    load_mul   = 1'b0;
    if (accept) begin
      if (is_mul) begin
        state_next = ST_BUSY;
      end else begin
        state_next = ST_DONE;
        load_alu   = 1'b1;
      end
    end else if (state == ST_BUSY && mul_done) begin
      state_next = ST_DONE;
      load_mul   = 1'b1;
    end else if (state == ST_DONE && bus.out_ready) begin
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (load_alu) begin
        result_q <= alu_res;
        flags_q  <= alu_flags;
        err_q    <= alu_err;
      end else if (load_mul) begin
        result_q <= mul_res;
        flags_q  <= mul_flags;
        err_q    <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = (state == ST_DONE);
  assign bus.result      = result_q;
  assign bus.flag_zero   = flags_q.zero;
  assign bus.flag_carry  = flags_q.carry;
  assign bus.flag_neg    = flags_q.neg;
  assign bus.flag_ovf    = flags_q.ovf;
  assign bus.err_illegal = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=8); multiply scenarios follow ALU_SEQ_MUL_EN.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  alu_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // {out_valid, err_illegal, zero, carry, neg, ovf, result}
  logic [13:0] obs;
  assign obs = {bus.out_valid, bus.err_illegal, bus.flag_zero, bus.flag_carry,
                bus.flag_neg, bus.flag_ovf, bus.result};

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs [10] = '{
    '{4'd2,  8'h00, 8'hFF, {6'b101100, 8'h00}},
    '{4'd2,  8'h00, 8'h7F, {6'b100011, 8'h80}},
    '{4'd3,  8'h00, 8'h00, {6'b100110, 8'hFF}},
    '{4'd3,  8'h00, 8'h80, {6'b100001, 8'h7F}},
    '{4'd8,  8'h01, 8'h00, {6'b101100, 8'h00}},
    '{4'd7,  8'h40, 8'h00, {6'b100010, 8'h80}},
    '{4'd10, 8'h00, 8'hA5, {6'b100010, 8'hA5}},
    '{4'd1,  8'h80, 8'h01, {6'b100001, 8'h7F}},
    '{4'd0,  8'h80, 8'h80, {6'b101101, 8'h00}},
    '{4'd1,  8'h03, 8'h03, {6'b101000, 8'h00}}
  };

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.op       = alu_op_e'(op);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    total++;
    if ({bus.in_ready, obs} !== 15'b0) begin
      bad++;
      $display("[TB] FAIL reset_state: got %h expected %h", {bus.in_ready, obs}, 15'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_release_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_add_sub();
    bus.out_ready = 1'b1;
    send(4'd0, 8'hFF, 8'h01);
    total++;
    if (obs !== {6'b101100, 8'h00}) begin
      bad++;
      $display("[TB] FAIL add_carry: got %h expected %h", obs, {6'b101100, 8'h00});
    end
    send(4'd1, 8'h05, 8'h07);
    total++;
    if (obs !== {6'b100110, 8'hFE}) begin
      bad++;
      $display("[TB] FAIL sub_borrow: got %h expected %h", obs, {6'b100110, 8'hFE});
    end
    send(4'd0, 8'h7F, 8'h01);
    total++;
    if (obs !== {6'b100011, 8'h80}) begin
      bad++;
      $display("[TB] FAIL add_ovf: got %h expected %h", obs, {6'b100011, 8'h80});
    end
    step();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL drain_to_idle: got %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_single_cycle_ops();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.op       = alu_op_e'(vecs[i].op);
      bus.a        = vecs[i].a;
      bus.b        = vecs[i].b;
      bus.in_valid = 1'b1;
      step();
      total++;
      if (obs !== vecs[i].exp) begin
        bad++;
        $display("[TB] FAIL op_vec%0d: got %h expected %h", i, obs, vecs[i].exp);
      end
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops  [3] = '{4'd6, 4'd5, 4'd4};
    logic [13:0] exps [3] = '{{6'b100010, 8'hCC}, {6'b100010, 8'hFC}, {6'b100000, 8'h30}};
    bus.out_ready = 1'b1;
    bus.a         = 8'hF0;
    bus.b         = 8'h3C;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.op = alu_op_e'(ops[i]);
      step();
      total++;
      if ({bus.in_ready, obs} !== {1'b1, exps[i]}) begin
        bad++;
        $display("[TB] FAIL stream%0d: got %h expected %h", i, {bus.in_ready, obs}, {1'b1, exps[i]});
      end
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    send(4'd7, 8'h81, 8'h00);
    bus.op       = OP_ADD;
    bus.a        = 8'h03;
    bus.b        = 8'h04;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({bus.in_ready, obs} !== {1'b0, 6'b100100, 8'h02}) begin
        bad++;
        $display("[TB] FAIL hold%0d: got %h expected %h", i, {bus.in_ready, obs}, {1'b0, 6'b100100, 8'h02});
      end
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    total++;
    if (obs !== {6'b100000, 8'h07}) begin
      bad++;
      $display("[TB] FAIL after_release: got %h expected %h", obs, {6'b100000, 8'h07});
    end
    step();
  endtask

  task automatic test_illegal();
    bus.out_ready = 1'b1;
    send(4'hF, 8'h12, 8'h34);
    total++;
    if (obs !== {6'b111000, 8'h00}) begin
      bad++;
      $display("[TB] FAIL illegal_f: got %h expected %h", obs, {6'b111000, 8'h00});
    end
    send(4'd5, 8'h12, 8'h34);
    total++;
    if (obs !== {6'b100000, 8'h36}) begin
      bad++;
      $display("[TB] FAIL err_clears: got %h expected %h", obs, {6'b100000, 8'h36});
    end
`ifndef ALU_SEQ_MUL_EN
    send(4'd9, 8'h10, 8'h11);
    total++;
    if (obs !== {6'b111000, 8'h00}) begin
      bad++;
      $display("[TB] FAIL mul_disabled: got %h expected %h", obs, {6'b111000, 8'h00});
    end
`endif
    step();
  endtask

  task automatic test_mul();
`ifdef ALU_SEQ_MUL_EN
    bus.out_ready = 1'b1;
    send(4'd9, 8'h10, 8'h11);
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
        bad++;
        $display("[TB] FAIL mul_busy%0d: got %b expected 00", i, {bus.in_ready, bus.out_valid});
      end
      step();
    end
    total++;
    if (obs !== {6'b100101, 8'h10}) begin
      bad++;
      $display("[TB] FAIL mul_result: got %h expected %h", obs, {6'b100101, 8'h10});
    end
    step();
`endif
  endtask

  task automatic test_reset_abort();
    bus.out_ready = 1'b0;
    send(4'd0, 8'h12, 8'h01);
    #3 rst = 1'b1;
    #1;
    total++;
    if ({bus.in_ready, obs} !== 15'b0) begin
      bad++;
      $display("[TB] FAIL abort_done: got %h expected %h", {bus.in_ready, obs}, 15'b0);
    end
    @(negedge clk);
    rst = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    bus.out_ready = 1'b1;
    send(4'd0, 8'h12, 8'h01);
    send(4'd9, 8'hFF, 8'hFF);
    step();
    step();
    #3 rst = 1'b1;
    #1;
    total++;
    if ({bus.in_ready, obs} !== 15'b0) begin
      bad++;
      $display("[TB] FAIL abort_mul: got %h expected %h", {bus.in_ready, obs}, 15'b0);
    end
    @(negedge clk);
    rst = 1'b0;
`endif
    step();
    total++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL abort_idle: got %b expected 10", {bus.in_ready, bus.out_valid});
    end
    bus.out_ready = 1'b1;
    send(4'd0, 8'h02, 8'h03);
    total++;
    if (obs !== {6'b100000, 8'h05}) begin
      bad++;
      $display("[TB] FAIL post_abort_add: got %h expected %h", obs, {6'b100000, 8'h05});
    end
    step();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.op        = OP_ADD;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_add_sub();
    test_single_cycle_ops();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_mul();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
